// File: rtl/basic_inverter_pkg.sv
// Shared constants and types for the basic_inverter leaf cell.
package basic_inverter_pkg;

  localparam int WIDTH_DEF = 1;
  localparam int CNT_W_DEF = 16;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  // out_q resets to the inverse of an all-zero input.
  localparam logic OUT_Q_RST_BIT = 1'b1;

endpackage

// File: rtl/inv_toggle_mon.sv
// Input-activity monitor: previous-input register, toggle pulse,
// saturating toggle counter and sticky self-check flag.
module inv_toggle_mon
  import basic_inverter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_i,
  input  logic [WIDTH-1:0] out_q_i,
  output logic             toggle_o,
  output logic [CNT_W-1:0] toggle_cnt_o,
  output logic             err_o
);

  logic [WIDTH-1:0] in_prev_q;
  logic             toggle_q, toggle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             change;

  assign change = (in_i != in_prev_q);

  always_comb begin
    toggle_d = change;
    cnt_d    = cnt_q;
    if (change && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // out_q and in_prev are loaded from the same sample, so they must stay inverse.
    err_d = err_q | (out_q_i != ~in_prev_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_prev_q <= '0;
      toggle_q  <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      in_prev_q <= in_i;
      toggle_q  <= toggle_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign toggle_o     = toggle_q;
  assign toggle_cnt_o = cnt_q;
  assign err_o        = err_q;

endmodule

// File: rtl/basic_inverter.sv
// Bit-wise inverter with registered copy; activity monitor built only
// when BASIC_INVERTER_STATS_EN is defined (outputs tied to 0 otherwise).
module basic_inverter
  import basic_inverter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             toggle,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             err
);

  logic [WIDTH-1:0] out_q_q, out_q_d;

  assign out     = ~in;
  assign out_q_d = ~in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_q <= {WIDTH{OUT_Q_RST_BIT}};
    end else begin
      out_q_q <= out_q_d;
    end
  end

  assign out_q = out_q_q;

`ifdef BASIC_INVERTER_STATS_EN
  inv_toggle_mon #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_mon (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_i        (in),
    .out_q_i     (out_q_q),
    .toggle_o    (toggle),
    .toggle_cnt_o(toggle_cnt),
    .err_o       (err)
  );
`else
  assign toggle     = 1'b0;
  assign toggle_cnt = '0;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_basic_inverter.sv
// Directed bench for basic_inverter: a default instance and a CNT_W=2
// instance share the same stimulus.
module tb_basic_inverter;

`ifdef BASIC_INVERTER_STATS_EN
  localparam bit S = 1'b1;
`else
  localparam bit S = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n;
  logic [0:0]  in;
  logic [0:0]  out, out_q, out_s, out_q_s;
  logic        toggle, err, toggle_s, err_s;
  logic [15:0] toggle_cnt;
  logic [1:0]  toggle_cnt_s;

  int vectors = 0;
  int miscompares = 0;

  basic_inverter #(.WIDTH(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .out(out), .out_q(out_q),
    .toggle(toggle), .toggle_cnt(toggle_cnt), .err(err)
  );

  basic_inverter #(.WIDTH(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in(in), .out(out_s), .out_q(out_q_s),
    .toggle(toggle_s), .toggle_cnt(toggle_cnt_s), .err(err_s)
  );

  always #5 clk = clk_en ? ~clk : clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat3(input int k);
    return (k > 3) ? 3 : k;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    in    = 1'b0;
    #1 rst_n = 1'b0;

    // combinational path with no clock running
    in = 1'b1; #100 check("comb_in1_a", out, 0);
    in = 1'b0; #60  check("comb_in0_a", out, 1);
    in = 1'b1; #80  check("comb_in1_b", out, 0);
    in = 1'b0; #100 check("comb_in0_b", out, 1);

    in = 1'b1; #1;
    check("rst_out_q", out_q, 1);
    check("rst_out_q_sat", out_q_s, 1);
    check("rst_cnt", toggle_cnt, 0);
    check("rst_toggle", toggle, 0);
    check("rst_err", err, 0);
    check("rst_out", out, 0);

    clk_en = 1'b1;
    tick();
    tick();
    check("rst_hold_out_q", out_q, 1);
    check("rst_hold_out", out, 0);

    in    = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rel_out_q", out_q, 1);
    check("rel_toggle", toggle, 0);
    check("rel_cnt", toggle_cnt, 0);

    for (int k = 1; k <= 4; k++) begin
      in = (k % 2 == 1) ? 1'b1 : 1'b0;
      if (k == 1) begin
        #2 check("lat_before_edge", out_q, 1);
      end
      tick();
      check($sformatf("pat%0d_out_q", k), out_q, {31'b0, ~in});
      check($sformatf("pat%0d_toggle", k), toggle, S ? 1 : 0);
      check($sformatf("pat%0d_cnt", k), toggle_cnt, S ? k : 0);
      check($sformatf("pat%0d_cnt_sat", k), toggle_cnt_s, S ? sat3(k) : 0);
      check($sformatf("pat%0d_err", k), err, 0);
    end

    tick();
    check("hold_toggle", toggle, 0);
    check("hold_cnt", toggle_cnt, S ? 4 : 0);
    check("hold_out_q", out_q, 1);

    in = 1'b1;
    tick();
    check("five_cnt", toggle_cnt, S ? 5 : 0);
    check("five_cnt_sat", toggle_cnt_s, S ? 3 : 0);
    check("five_toggle_sat", toggle_s, S ? 1 : 0);

    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cnt", toggle_cnt, 0);
    check("mid_rst_cnt_sat", toggle_cnt_s, 0);
    check("mid_rst_out_q", out_q, 1);
    check("mid_rst_toggle", toggle, 0);
    check("mid_rst_out", out, 0);
    in = 1'b0; #1;
    check("mid_rst_out_track", out, 1);

    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      in = (k % 2 == 1) ? 1'b1 : 1'b0;
      tick();
      check($sformatf("sat%0d_toggle", k), toggle_s, S ? 1 : 0);
      check($sformatf("sat%0d_cnt_sat", k), toggle_cnt_s, S ? sat3(k) : 0);
      check($sformatf("sat%0d_cnt", k), toggle_cnt, S ? k : 0);
      check($sformatf("sat%0d_out_q", k), out_q_s, {31'b0, ~in});
    end

    tick();
    check("end_err", err, 0);
    check("end_err_sat", err_s, 0);
    check("end_toggle", toggle_s, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/basic_inverter.md
Name: basic_inverter

Overview:
Bit-wise logic inverter with a purely combinational primary path (out = ~in). It also provides a registered copy of the inverted value and input-activity monitoring on a single clock domain. It is used as a leaf cell wherever a polarity flip is needed, and as a smoke-test block for tool flows. The combinational path has no dependence on clock or reset, so it is correct even when the clock is not running.

Parameters:
WIDTH, 1, bit width of in/out/out_q
CNT_W, 16, width of toggle counter (saturating)

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in  input  WIDTH  data to invert
out  output  WIDTH  combinational inverse, ~in
out_q  output  WIDTH  registered inverse, ~in sampled at clk
toggle  output  1  pulse: in differs from previous sampled in
toggle_cnt  output  CNT_W  saturating count of toggle events
err  output  1  sticky self-check mismatch flag

Behaviour:
- out = ~in, bit-wise, zero latency.
  - No clock or reset dependence.
  - A 0 on in gives 1 on out, and 1 gives 0, within the same delta.
  - X/Z on in propagates as X on out.
- Asynchronous reset while rst_n = 0:
  - out_q = all ones (the inverse of an all-zero input).
  - in_prev = 0.
  - toggle = 0, toggle_cnt = 0, err = 0.
  - out is unaffected by reset.
- Reset release is synchronous to clk. The first edge after release samples normally.
- Each rising clk edge with rst_n = 1:
  - out_q <= ~in, 1-cycle latency.
  - in_prev <= in.
  - toggle <= (in != in_prev), registered, high for exactly one cycle per change.
- Counter update:
  - When (in != in_prev), toggle_cnt increments.
  - toggle_cnt saturates at 2^CNT_W-1 and never wraps.
- Self-check: each edge compares out_q against ~in_prev (the value it was loaded from). Any mismatch sets err, which stays set until reset.
- Simultaneous events: change on in in the same cycle the counter saturates → toggle still pulses, count holds at max.
- Reset asserted mid-operation: all registered outputs go to reset values immediately (asynchronously). out keeps tracking in.
- No handshake and no back-pressure. in is assumed synchronous to clk for the registered paths only.

Optional Feature:
BASIC_INVERTER_STATS_EN
- Defined: the toggle, toggle_cnt and err logic is built as described.
- Not defined:
  - toggle, toggle_cnt and err are tied to 0.
  - Their registers are not instantiated.
  - out and out_q are unchanged.
- The port list is identical in both builds.

Decomposition:
- Package basic_inverter_pkg holds:
  - default WIDTH and CNT_W constants;
  - a typedef for the counter (logic [CNT_W-1:0]);
  - the OUT_Q_RST function/constant ('1).
- One sub-module is natural: inv_toggle_mon (in_prev register, toggle pulse, saturating counter, err flag). It is instantiated only under BASIC_INVERTER_STATS_EN.
- The combinational inverter and out_q register stay in the top.

Test Plan:
- Combinational, no clock: in=1, wait 100 → out=0; in=0, wait 60 → out=1; in=1, wait 80 → out=0; in=0, wait 100 → out=1.
- Reset: rst_n=0 with in=1 → out_q=1 (WIDTH=1), toggle_cnt=0, err=0, out=0 throughout.
- Registered latency: release reset, in=1 before edge N → out_q=0 after edge N, not before. Then in=0 → out_q=1 one edge later.
- Toggle counting: drive pattern 1,0,1,0 on four consecutive edges from in_prev=0 → four toggle pulses, toggle_cnt=4. Hold in → toggle=0, count stays 4.
- Saturation: CNT_W=2, toggle in every cycle for 6 cycles → toggle_cnt sticks at 3, toggle still pulses.
- Mid-operation reset: assert rst_n=0 asynchronously between edges with toggle_cnt=5 → toggle_cnt=0 and out_q=all ones immediately, out still equals ~in. Build without BASIC_INVERTER_STATS_EN → toggle, toggle_cnt, err constantly 0.
